subtractor_nibble_serial_8b: RTL and testbench

- Sequential 8-bit subtractor/comparator. Computes in0 - in1 one CHUNK-bit slice per cycle on a single ripple-carry slice adder: the inverted subtrahend is fed in, and the carry is chained through a register.
- Provides the subtract/compare direction of the datapath arithmetic: difference plus unsigned and signed compare flags.
- Uses a val/rdy request/response handshake so it can sit behind the ALU or a branch-compare unit as a low-area multi-cycle unit.

---
 rtl/subtractor_nibble_serial_8b_pkg.sv | 22 ++
 rtl/adder_ripple_carry_nb.sv | 24 ++
 rtl/subtractor_nibble_serial_8b.sv | 107 ++++++++++
 tb/tb_subtractor_nibble_serial_8b.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/subtractor_nibble_serial_8b_pkg.sv
// Shared definitions for the nibble-serial subtractor: FSM encoding,
// default geometry and chunk-index sizing.
package subtractor_nibble_serial_8b_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned DEF_NBITS   = 8;
    localparam int unsigned DEF_CHUNK   = 4;
    localparam int unsigned DEF_NCHUNKS = DEF_NBITS / DEF_CHUNK;

    // A single-chunk configuration still needs a one-bit index register.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    localparam int unsigned DEF_KW = idx_width(DEF_NCHUNKS);

endpackage

// File: rtl/adder_ripple_carry_nb.sv
// W-bit ripple-carry adder slice with carry in and carry out.
module adder_ripple_carry_nb #(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    input  logic         cin,
    output logic [W-1:0] s,
    output logic         cout
);

    logic c;

    always_comb begin
        s = '0;
        c = cin;
        for (int unsigned i = 0; i < W; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end

endmodule

// File: rtl/subtractor_nibble_serial_8b.sv
// Multi-cycle subtractor/comparator: in0 - in1 computed CHUNK bits per cycle
// through one ripple slice, with unsigned/signed compare flags.
module subtractor_nibble_serial_8b
    import subtractor_nibble_serial_8b_pkg::*;
#(
    parameter int unsigned NBITS = DEF_NBITS,
    parameter int unsigned CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_val,
    output logic             req_rdy,
    input  logic [NBITS-1:0] in0,
    input  logic [NBITS-1:0] in1,
    output logic             resp_val,
    input  logic             resp_rdy,
    output logic [NBITS-1:0] diff,
    output logic             borrow,
    output logic             zero,
    output logic             ovf,
    output logic             neg
);

    localparam int unsigned   NCHUNKS = NBITS / CHUNK;
    localparam int unsigned   KW      = idx_width(NCHUNKS);
    localparam logic [KW-1:0] KLAST   = KW'(NCHUNKS - 1);

    state_t           state, state_nx;
    logic [KW-1:0]    k;
    logic             carry;
    logic [NBITS-1:0] a, b, diff_nx;
    logic [CHUNK-1:0] a_sl, nb_sl, s_sl;
    logic             cout, last, ovf_nx;

    assign a_sl  = a[k*CHUNK +: CHUNK];
    assign nb_sl = ~b[k*CHUNK +: CHUNK];
    assign last  = (k == KLAST);

    adder_ripple_carry_nb #(.W(CHUNK)) u_add (
        .a    (a_sl),
        .b    (nb_sl),
        .cin  (carry),
        .s    (s_sl),
        .cout (cout)
    );

    // Flags on the last slice must see the slice being written this cycle.
    always_comb begin
        diff_nx                    = diff;
        diff_nx[k*CHUNK +: CHUNK]  = s_sl;
        ovf_nx = (a[NBITS-1] != b[NBITS-1]) && (diff_nx[NBITS-1] != a[NBITS-1]);
    end

    assign req_rdy  = rst && (state == IDLE);
    assign resp_val = (state == DONE);

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (req_val)  state_nx = CALC;
            CALC:    if (last)     state_nx = DONE;
            DONE:    if (resp_rdy) state_nx = IDLE;
            default:               state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nx;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            k      <= '0;
            carry  <= 1'b0;
            a      <= '0;
            b      <= '0;
            diff   <= '0;
            borrow <= 1'b0;
            zero   <= 1'b0;
            ovf    <= 1'b0;
            neg    <= 1'b0;
        end else begin
            case (state)
                IDLE: if (req_val) begin
                    a     <= in0;
                    b     <= in1;
                    k     <= '0;
                    carry <= 1'b1;
                end
                CALC: begin
                    diff  <= diff_nx;
                    carry <= cout;
                    k     <= k + 1'b1;
                    if (last) begin
                        borrow <= ~cout;
                        zero   <= (diff_nx == '0);
                        ovf    <= ovf_nx;
                        neg    <= diff_nx[NBITS-1] ^ ovf_nx;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_subtractor_nibble_serial_8b.sv
// Directed bench for subtractor_nibble_serial_8b: arithmetic reference model
// checked every cycle, plus literal expectations per test vector.
module tb_subtractor_nibble_serial_8b;

    localparam int NB = 8;
    localparam int NCH = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          req_val = 1'b0;
    logic          resp_rdy = 1'b0;
    logic [NB-1:0] in0 = '0;
    logic [NB-1:0] in1 = '0;
    logic          req_rdy, resp_val, borrow, zero, ovf, neg;
    logic [NB-1:0] diff;

    int n_checks = 0;
    int n_pass   = 0;

    subtractor_nibble_serial_8b #(.NBITS(8), .CHUNK(4)) dut (
        .clk      (clk),
        .rst      (rst),
        .req_val  (req_val),
        .req_rdy  (req_rdy),
        .in0      (in0),
        .in1      (in1),
        .resp_val (resp_val),
        .resp_rdy (resp_rdy),
        .diff     (diff),
        .borrow   (borrow),
        .zero     (zero),
        .ovf      (ovf),
        .neg      (neg)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: protocol timing plus plain integer arithmetic.
    bit            m_idle = 1'b1;
    bit            m_resp = 1'b0;
    int            m_wait = 0;
    logic [NB-1:0] e_diff;
    logic          e_borrow, e_zero, e_ovf, e_neg;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_idle = 1'b1;
            m_resp = 1'b0;
            m_wait = 0;
        end else if (m_idle) begin
            if (req_val) begin
                int sa, sb, sd;
                sa = $signed(in0);
                sb = $signed(in1);
                sd = sa - sb;
                e_diff   = NB'((int'(in0) - int'(in1)) & 255);
                e_borrow = (int'(in0) < int'(in1));
                e_zero   = (in0 == in1);
                e_ovf    = (sd > 127) || (sd < -128);
                e_neg    = (sd < 0);
                m_idle   = 1'b0;
                m_wait   = NCH;
            end
        end else if (!m_resp) begin
            m_wait--;
            if (m_wait == 0) m_resp = 1'b1;
        end else if (resp_rdy) begin
            m_resp = 1'b0;
            m_idle = 1'b1;
        end
    end

    always @(negedge clk) begin
        chk("model req_rdy", req_rdy, rst && m_idle);
        chk("model resp_val", resp_val, m_resp);
        if (m_resp) begin
            chk("model diff", diff, e_diff);
            chk("model borrow", borrow, e_borrow);
            chk("model zero", zero, e_zero);
            chk("model ovf", ovf, e_ovf);
            chk("model neg", neg, e_neg);
        end
    end

    task automatic wait_resp(input int start, output int n);
        n = start;
        while (!resp_val && n < 12) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic lit(input string tag, input logic [7:0] ed,
                       input logic eb, ez, eo, en);
        chk({tag, " diff"}, diff, ed);
        chk({tag, " borrow"}, borrow, eb);
        chk({tag, " zero"}, zero, ez);
        chk({tag, " ovf"}, ovf, eo);
        chk({tag, " neg"}, neg, en);
    endtask

    task automatic op(input string tag, input logic [7:0] a, b, ed,
                      input logic eb, ez, eo, en);
        int n;
        @(negedge clk); #1;
        in0 = a; in1 = b; req_val = 1'b1; resp_rdy = 1'b0;
        chk({tag, " req_rdy"}, req_rdy, 1'b1);
        @(posedge clk); #1;
        req_val = 1'b0; in0 = ~a; in1 = a;
        wait_resp(0, n);
        chk({tag, " latency"}, n, 3);
        lit(tag, ed, eb, ez, eo, en);
        #1 resp_rdy = 1'b1;
        @(posedge clk); #1 resp_rdy = 1'b0;
    endtask

    initial begin
        int n;
        #100000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        repeat (2) @(negedge clk);
        chk("reset req_rdy", req_rdy, 1'b0);
        chk("reset resp_val", resp_val, 1'b0);
        lit("reset", 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        #1 rst = 1'b1;

        op("basic",     8'h35, 8'h12, 8'h23, 1'b0, 1'b0, 1'b0, 1'b0);
        op("xslice",    8'h10, 8'h01, 8'h0F, 1'b0, 1'b0, 1'b0, 1'b0);
        op("underflow", 8'h00, 8'h01, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1);
        op("ovf_neg",   8'h80, 8'h01, 8'h7F, 1'b0, 1'b0, 1'b1, 1'b1);
        op("ovf_pos",   8'h7F, 8'hFF, 8'h80, 1'b1, 1'b0, 1'b1, 1'b0);

        // Equal operands under backpressure, req_val held high throughout.
        @(negedge clk); #1;
        in0 = 8'h5A; in1 = 8'h5A; req_val = 1'b1; resp_rdy = 1'b0;
        @(posedge clk);
        @(negedge clk);
        wait_resp(1, n);
        chk("bp latency", n, 3);
        lit("bp", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        repeat (4) begin
            @(negedge clk);
            chk("bp req_rdy", req_rdy, 1'b0);
            chk("bp resp_val", resp_val, 1'b1);
            lit("bp hold", 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        #1 resp_rdy = 1'b1; in0 = 8'h01; in1 = 8'h02;
        @(posedge clk); #1 resp_rdy = 1'b0;
        @(negedge clk);
        chk("post-resp resp_val", resp_val, 1'b0);
        chk("post-resp req_rdy", req_rdy, 1'b1);
        @(posedge clk); #1 req_val = 1'b0;
        @(negedge clk);
        chk("next busy req_rdy", req_rdy, 1'b0);
        wait_resp(1, n);
        chk("next latency", n, 3);
        lit("next", 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1);
        #1 resp_rdy = 1'b1;
        @(posedge clk); #1 resp_rdy = 1'b0;

        // Reset during the first CALC cycle.
        @(negedge clk); #1;
        in0 = 8'h35; in1 = 8'h12; req_val = 1'b1; resp_rdy = 1'b1;
        @(posedge clk); #2;
        rst = 1'b0; req_val = 1'b0;
        #1;
        chk("mid-reset req_rdy", req_rdy, 1'b0);
        chk("mid-reset resp_val", resp_val, 1'b0);
        repeat (2) @(negedge clk);
        chk("in-reset resp_val", resp_val, 1'b0);
        #1 rst = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("after reset no resp", resp_val, 1'b0);
        end
        op("post_reset", 8'h03, 8'h05, 8'hFE, 1'b1, 1'b0, 1'b0, 1'b1);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
